aemb2_xwb_fifo_slave: RTL

Wishbone responder for the AEMB2 XSL (xwb) accelerator bus. It is the far end of the core's put/get instructions.
- Core writes (put) go into a put FIFO, which drains to an external valid/ready stream.
- Core reads (get) are taken from a get FIFO, which fills from an external valid/ready stream.
- A data access stalls the core by withholding ack: writes while the put FIFO is full, reads while the get FIFO is empty. This gives blocking FSL semantics.

---
 rtl/aemb2_xsl_pkg.sv | 35 +++
 rtl/aemb2_xsl_fifo.sv | 72 +++++++
 rtl/aemb2_xwb_fifo_slave.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/aemb2_xsl_pkg.sv
// Shared constants and types for the AEMB2 XSL (xwb) FIFO responder.
// Address decode, status word layout, control bits, FSM states, FIFO word.
package aemb2_xsl_pkg;

    localparam int unsigned XSL_DW = 32;

    // xwb_adr_i[2] decode
    localparam logic XSL_ADR_DATA = 1'b0;
    localparam logic XSL_ADR_STAT = 1'b1;

    // Status word bit positions
    localparam int unsigned STAT_TAG      = 31;
    localparam int unsigned STAT_PFULL    = 30;
    localparam int unsigned STAT_GEMPTY   = 29;
    localparam int unsigned STAT_PCNT_MSB = 15;
    localparam int unsigned STAT_PCNT_LSB = 8;
    localparam int unsigned STAT_GCNT_MSB = 7;
    localparam int unsigned STAT_GCNT_LSB = 0;

    // Control word bits
    localparam int unsigned CTL_PFLUSH = 0;
    localparam int unsigned CTL_GFLUSH = 1;

    typedef enum logic {
        XSL_IDLE = 1'b0,
        XSL_ACK  = 1'b1
    } xsl_state_e;

    // FIFO entry: control tag above the data word
    typedef struct packed {
        logic              tag;
        logic [XSL_DW-1:0] dat;
    } xsl_word_t;

endpackage

// File: rtl/aemb2_xsl_fifo.sv
// Synchronous first-word-fall-through FIFO with flush.
// Ports: clk_i, rst_i (sync, active-high), flush_i, push_i/dat_i,
//        pop_i, dat_o (head, zero when empty), count_o, full_o, empty_o.
module aemb2_xsl_fifo #(
    parameter int unsigned DW = 33,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] dat_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_c, pop_c;

    // Status and guarded push/pop; push into a full FIFO is legal only alongside a pop
    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == FULL_CNT);
        count_o = count_q;
        dat_o   = empty_o ? '0 : mem_q[rd_ptr_q];
        pop_c   = pop_i & ~empty_o & ~flush_i;
        push_c  = push_i & ~flush_i & (~full_o | pop_c);
    end

    // Pointer/count update; flush wins over any same-cycle push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care outside the valid window
    always_ff @(posedge clk_i) begin
        if (push_c) mem_q[wr_ptr_q] <= dat_i;
    end

endmodule

// File: rtl/aemb2_xwb_fifo_slave.sv
// Wishbone responder for the AEMB2 xwb accelerator bus (put/get FSL semantics).
// Ports: sys_clk_i/sys_rst_i (sync active-high); xwb_* bus slave with
//        single-cycle ack; put_* outgoing valid/ready stream; get_* incoming
//        valid/ready stream. Data accesses stall by withholding ack.
module aemb2_xwb_fifo_slave
    import aemb2_xsl_pkg::*;
#(
    parameter int unsigned AEMB_XWB = 3,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    input  logic                xwb_cyc_i,
    input  logic                xwb_stb_i,
    input  logic                xwb_wre_i,
    input  logic                xwb_tag_i,
    input  logic [AEMB_XWB-1:2] xwb_adr_i,
    input  logic [3:0]          xwb_sel_i,
    input  logic [31:0]         xwb_dat_i,
    output logic [31:0]         xwb_dat_o,
    output logic                xwb_ack_o,
    output logic [31:0]         put_dat_o,
    output logic                put_tag_o,
    output logic                put_vld_o,
    input  logic                put_rdy_i,
    input  logic [31:0]         get_dat_i,
    input  logic                get_tag_i,
    input  logic                get_vld_i,
    output logic                get_rdy_o
);

    localparam int unsigned CW = FIFO_AW + 1;

    xsl_state_e  state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    xsl_word_t   put_head_c, get_head_c, put_in_c, get_in_c;
    logic [CW-1:0] put_cnt_c, get_cnt_c;
    logic        put_full_c, put_empty_c, get_full_c, get_empty_c;
    logic        put_push_c, put_pop_c, get_push_c, get_pop_c;
    logic        put_flush_c, get_flush_c;
    logic        req_c;
    logic [31:0] stat_c;
    logic        unused_c;

    // Byte selects and upper address bits carry no meaning here
    assign unused_c = ^{xwb_sel_i, xwb_adr_i};

    aemb2_xsl_fifo #(.DW(XSL_DW + 1), .AW(FIFO_AW)) u_put_fifo (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_i),
        .flush_i (put_flush_c),
        .push_i  (put_push_c),
        .dat_i   (put_in_c),
        .pop_i   (put_pop_c),
        .dat_o   (put_head_c),
        .count_o (put_cnt_c),
        .full_o  (put_full_c),
        .empty_o (put_empty_c)
    );

    aemb2_xsl_fifo #(.DW(XSL_DW + 1), .AW(FIFO_AW)) u_get_fifo (
        .clk_i   (sys_clk_i),
        .rst_i   (sys_rst_i),
        .flush_i (get_flush_c),
        .push_i  (get_push_c),
        .dat_i   (get_in_c),
        .pop_i   (get_pop_c),
        .dat_o   (get_head_c),
        .count_o (get_cnt_c),
        .full_o  (get_full_c),
        .empty_o (get_empty_c)
    );

    // Stream-side handshakes and status word assembly
    always_comb begin
        put_vld_o  = ~put_empty_c;
        put_dat_o  = put_head_c.dat;
        put_tag_o  = put_head_c.tag;
        put_pop_c  = put_vld_o & put_rdy_i;
        get_rdy_o  = ~get_full_c;
        get_push_c = get_vld_i & get_rdy_o;
        put_in_c   = '{tag: xwb_tag_i, dat: xwb_dat_i};
        get_in_c   = '{tag: get_tag_i, dat: get_dat_i};

        stat_c                              = '0;
        stat_c[STAT_TAG]                    = get_head_c.tag;
        stat_c[STAT_PFULL]                  = put_full_c;
        stat_c[STAT_GEMPTY]                 = get_empty_c;
        stat_c[STAT_PCNT_MSB:STAT_PCNT_LSB] = 8'(put_cnt_c);
        stat_c[STAT_GCNT_MSB:STAT_GCNT_LSB] = 8'(get_cnt_c);
    end

    // Bus FSM: IDLE waits for resource, ACK holds ack for exactly one cycle
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_d       = '0;
        put_push_c  = 1'b0;
        get_pop_c   = 1'b0;
        put_flush_c = 1'b0;
        get_flush_c = 1'b0;
        req_c       = xwb_cyc_i & xwb_stb_i & ~ack_q;

        unique case (state_q)
            XSL_IDLE: begin
                if (req_c) begin
                    unique case (xwb_adr_i[2])
                        XSL_ADR_DATA: begin
                            if (xwb_wre_i) begin
                                // A full FIFO still accepts when the stream pops this cycle
                                if (~put_full_c | put_pop_c) begin
                                    put_push_c = 1'b1;
                                    ack_d      = 1'b1;
                                    state_d    = XSL_ACK;
                                end
                            end else if (~get_empty_c) begin
                                get_pop_c = 1'b1;
                                dat_d     = get_head_c.dat;
                                ack_d     = 1'b1;
                                state_d   = XSL_ACK;
                            end
                        end
                        XSL_ADR_STAT: begin
                            ack_d   = 1'b1;
                            state_d = XSL_ACK;
                            if (xwb_wre_i) begin
                                put_flush_c = xwb_dat_i[CTL_PFLUSH];
                                get_flush_c = xwb_dat_i[CTL_GFLUSH];
                            end else begin
                                dat_d = stat_c;
                            end
                        end
                    endcase
                end
            end
            XSL_ACK: begin
                state_d = XSL_IDLE;
            end
            default: begin
                state_d = XSL_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q <= XSL_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign xwb_ack_o = ack_q;
    assign xwb_dat_o = dat_q;

endmodule
